sdram_rr_arbiter: RTL and testbench

//  N-port round-robin arbiter for sharing one SDRAM controller slave among NUM_MASTERS

---
 rtl/sdram_rr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sdram_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rr_arbiter.sv
// sdram_rr_arbiter: N-port round-robin arbiter sharing one SDRAM controller slave.
// Optional macro ARB_HOLD_EN: lets one master keep the bus for up to HOLD_BEATS grants.
//
// Ports:
//   clk_clk, reset_reset_n          clock, async active-low reset
//   m_read/m_write                  per-master Avalon-MM requests (write wins if both)
//   m_address/writedata/byteenable  packed per-master command fields
//   m_waitrequest                   low only in the cycle master i's transfer is accepted
//   m_readdata/m_readdatavalid      broadcast read data, one-hot return strobe
//   sd_*                            registered command to / returns from the controller
//   err_orphan                      sticky: read return arrived with no tag outstanding
module sdram_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4,
    parameter int HOLD_BEATS  = 8
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset_n,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
    output logic [NUM_MASTERS-1:0]          m_waitrequest,
    output logic [DATA_W-1:0]               m_readdata,
    output logic [NUM_MASTERS-1:0]          m_readdatavalid,
    output logic [ADDR_W-1:0]               sd_address,
    output logic                            sd_read,
    output logic                            sd_write,
    output logic [DATA_W-1:0]               sd_writedata,
    output logic [DATA_W/8-1:0]             sd_byteenable,
    input  logic                            sd_waitrequest,
    input  logic [DATA_W-1:0]               sd_readdata,
    input  logic                            sd_readdatavalid,
    output logic                            err_orphan
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int BW = DATA_W / 8;
    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 ||
        MAX_PENDING < 2 || MAX_PENDING > 16 ||
        (MAX_PENDING & (MAX_PENDING - 1)) != 0 ||
        HOLD_BEATS < 1 || (DATA_W % 8) != 0) begin : g_bad_params
        $error("sdram_rr_arbiter: unsupported parameter set");
    end

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];
    logic [BW-1:0]     be_arr    [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] elig;
    logic [IW-1:0]     pick, g, rr_ptr, g_inc, rr_nxt;
    logic              any_elig, accept, push, pop, orphan;
    logic [IW-1:0]     tag_mem [MAX_PENDING];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     tag_cnt;
    int                idx;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            addr_arr[i]  = m_address[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = m_writedata[i*DATA_W +: DATA_W];
            be_arr[i]    = m_byteenable[i*BW +: BW];
        end
    end

    // A pending read only blocks its master once the tag FIFO is full.
    assign elig = m_write | (m_read & {NUM_MASTERS{tag_cnt < CW'(MAX_PENDING)}});

    // Walk downward so the lowest offset from rr_ptr is the last (winning) hit.
    always_comb begin
        pick     = '0;
        any_elig = 1'b0;
        idx      = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (elig[IW'(idx)]) begin
                pick     = IW'(idx);
                any_elig = 1'b1;
            end
        end
    end

    assign accept = (state == REQ) && !sd_waitrequest;
    assign push   = accept && sd_read;
    assign pop    = sd_readdatavalid && (tag_cnt != '0);
    assign orphan = sd_readdatavalid && (tag_cnt == '0);
    assign g_inc  = (g == IW'(NUM_MASTERS - 1)) ? '0 : g + IW'(1);

`ifdef ARB_HOLD_EN
    localparam int HW = $clog2(HOLD_BEATS + 1);
    logic [HW-1:0] hold_cnt, hold_inc;
    logic          hold_keep;

    // hold_inc counts grants already given to g, including this one.
    assign hold_inc  = hold_cnt + HW'(1);
    assign hold_keep = elig[g] && (hold_inc < HW'(HOLD_BEATS));
    assign rr_nxt    = hold_keep ? g : g_inc;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hold_cnt <= '0;
        end else if (accept) begin
            hold_cnt <= hold_keep ? hold_inc : '0;
        end
    end
`else
    assign rr_nxt = g_inc;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        m_waitrequest = '1;
        unique case (state)
            IDLE: begin
                if (any_elig) state_nxt = REQ;
            end
            REQ: begin
                if (!sd_waitrequest) begin
                    state_nxt        = IDLE;
                    m_waitrequest[g] = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sd_address    <= '0;
            sd_read       <= 1'b0;
            sd_write      <= 1'b0;
            sd_writedata  <= '0;
            sd_byteenable <= '0;
            g             <= '0;
            rr_ptr        <= '0;
        end else if (state == IDLE) begin
            if (any_elig) begin
                sd_address    <= addr_arr[pick];
                sd_writedata  <= wdata_arr[pick];
                sd_byteenable <= be_arr[pick];
                sd_write      <= m_write[pick];
                sd_read       <= !m_write[pick];
                g             <= pick;
            end
        end else if (accept) begin
            sd_read  <= 1'b0;
            sd_write <= 1'b0;
            rr_ptr   <= rr_nxt;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < MAX_PENDING; i++) tag_mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_cnt    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= g;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) tag_cnt <= tag_cnt + CW'(1);
            else if (pop && !push) tag_cnt <= tag_cnt - CW'(1);
            if (orphan) err_orphan <= 1'b1;
        end
    end

    assign m_readdata      = sd_readdata;
    assign m_readdatavalid = pop ? (NUM_MASTERS'(1) << tag_mem[rd_ptr]) : '0;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// tb_sdram_rr_arbiter: directed vector table plus hand sequences
// for round-robin order, read stall, tag routing, waitrequest hold and orphans.
module tb_sdram_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 24;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset_reset_n;
    logic [N-1:0]      m_read, m_write;
    logic [N*AW-1:0]   m_address;
    logic [N*DW-1:0]   m_writedata;
    logic [N*DW/8-1:0] m_byteenable;
    logic [N-1:0]      m_waitrequest, m_readdatavalid;
    logic [DW-1:0]     m_readdata;
    logic [AW-1:0]     sd_address;
    logic              sd_read, sd_write;
    logic [DW-1:0]     sd_writedata;
    logic [DW/8-1:0]   sd_byteenable;
    logic              sd_waitrequest;
    logic [DW-1:0]     sd_readdata;
    logic              sd_readdatavalid;
    logic              err_orphan;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    sdram_rr_arbiter dut (
        .clk_clk          (clk),
        .reset_reset_n    (reset_reset_n),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_address        (m_address),
        .m_writedata      (m_writedata),
        .m_byteenable     (m_byteenable),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid),
        .sd_address       (sd_address),
        .sd_read          (sd_read),
        .sd_write         (sd_write),
        .sd_writedata     (sd_writedata),
        .sd_byteenable    (sd_byteenable),
        .sd_waitrequest   (sd_waitrequest),
        .sd_readdata      (sd_readdata),
        .sd_readdatavalid (sd_readdatavalid),
        .err_orphan       (err_orphan)
    );

    typedef struct {
        logic [3:0]  rd, wr;
        logic        sw, srv;
        logic [15:0] srd;
        logic        e_sr, e_sw;
        logic [23:0] e_addr;
        logic [3:0]  e_mwr, e_rdv;
        logic        e_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m_read           = '0;
        m_write          = '0;
        sd_waitrequest   = 1'b0;
        sd_readdatavalid = 1'b0;
        sd_readdata      = '0;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        idle_inputs();
        #1;
        @(posedge clk); #1;
        reset_reset_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_read(input int m);
        bit ok;
        ok     = 1'b0;
        m_read = 4'b0001 << m;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (m_waitrequest[m] == 1'b0) ok = 1'b1;
            next_cycle();
        end
        m_read = '0;
        chk($sformatf("read accept m%0d", m), 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] one;
        logic [3:0] exp_mwr;
        logic [3:0] exp_rdv [4];
        int idx;
        one = 4'b0001;

        for (int i = 0; i < N; i++) begin
            m_address[i*AW +: AW]   = 24'h000100 + 24'(i);
            m_writedata[i*DW +: DW] = 16'hA000 + 16'(i);
        end
        m_byteenable = 8'b01_10_11_01;

        tbl[0]  = '{4'h0, 4'h0, 0, 0, 16'h0000, 0, 0, 24'h000000, 4'hF, 4'h0, 0};
        tbl[1]  = '{4'h0, 4'h4, 0, 0, 16'h0000, 0, 0, 24'h000000, 4'hF, 4'h0, 0};
        tbl[2]  = '{4'h0, 4'h4, 1, 0, 16'h0000, 0, 1, 24'h000102, 4'hF, 4'h0, 0};
        tbl[3]  = '{4'h0, 4'h4, 0, 0, 16'h0000, 0, 1, 24'h000102, 4'hB, 4'h0, 0};
        tbl[4]  = '{4'h0, 4'h0, 0, 0, 16'h0000, 0, 0, 24'h000102, 4'hF, 4'h0, 0};
        tbl[5]  = '{4'h3, 4'h0, 0, 0, 16'h0000, 0, 0, 24'h000102, 4'hF, 4'h0, 0};
        tbl[6]  = '{4'h3, 4'h0, 0, 0, 16'h0000, 1, 0, 24'h000100, 4'hE, 4'h0, 0};
        tbl[7]  = '{4'h2, 4'h0, 0, 0, 16'h0000, 0, 0, 24'h000100, 4'hF, 4'h0, 0};
        tbl[8]  = '{4'h2, 4'h0, 0, 0, 16'h0000, 1, 0, 24'h000101, 4'hD, 4'h0, 0};
        tbl[9]  = '{4'h0, 4'h0, 0, 1, 16'h1234, 0, 0, 24'h000101, 4'hF, 4'h1, 0};
        tbl[10] = '{4'h0, 4'h0, 0, 1, 16'h5678, 0, 0, 24'h000101, 4'hF, 4'h2, 0};
        tbl[11] = '{4'h0, 4'h0, 0, 1, 16'h9ABC, 0, 0, 24'h000101, 4'hF, 4'h0, 0};
        tbl[12] = '{4'h0, 4'h0, 0, 0, 16'h0000, 0, 0, 24'h000101, 4'hF, 4'h0, 1};

        // Reset state, checked while reset is held.
        reset_reset_n = 1'b0;
        idle_inputs();
        #1;
        chk("reset sd_read", 32'(sd_read), 32'd0);
        chk("reset sd_write", 32'(sd_write), 32'd0);
        chk("reset sd_address", 32'(sd_address), 32'd0);
        chk("reset m_waitrequest", 32'(m_waitrequest), 32'hF);
        chk("reset m_readdatavalid", 32'(m_readdatavalid), 32'd0);
        chk("reset err_orphan", 32'(err_orphan), 32'd0);
        next_cycle();
        reset_reset_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            m_read           = tbl[i].rd;
            m_write          = tbl[i].wr;
            sd_waitrequest   = tbl[i].sw;
            sd_readdatavalid = tbl[i].srv;
            sd_readdata      = tbl[i].srd;
            @(negedge clk);
            chk($sformatf("v%0d sd_read", i), 32'(sd_read), 32'(tbl[i].e_sr));
            chk($sformatf("v%0d sd_write", i), 32'(sd_write), 32'(tbl[i].e_sw));
            chk($sformatf("v%0d sd_address", i), 32'(sd_address), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d m_waitrequest", i), 32'(m_waitrequest), 32'(tbl[i].e_mwr));
            chk($sformatf("v%0d m_readdatavalid", i), 32'(m_readdatavalid), 32'(tbl[i].e_rdv));
            chk($sformatf("v%0d m_readdata", i), 32'(m_readdata), 32'(tbl[i].srd));
            chk($sformatf("v%0d err_orphan", i), 32'(err_orphan), 32'(tbl[i].e_err));
            next_cycle();
        end

        // Grant order under continuous writes.
        do_reset();
`ifdef ARB_HOLD_EN
        for (int c = 0; c < 40; c++) begin
            m_write = 4'b0011;
            @(negedge clk);
            idx     = (((c - 1) / 2) / 8) % 2;
            exp_mwr = (c % 2 == 1) ? ~(one << idx) : 4'hF;
            chk($sformatf("hold c%0d m_waitrequest", c), 32'(m_waitrequest), 32'(exp_mwr));
            next_cycle();
        end
`else
        for (int c = 0; c < 16; c++) begin
            m_write = 4'hF;
            @(negedge clk);
            idx     = ((c - 1) / 2) % 4;
            exp_mwr = (c % 2 == 1) ? ~(one << idx) : 4'hF;
            chk($sformatf("rr c%0d m_waitrequest", c), 32'(m_waitrequest), 32'(exp_mwr));
            if (c % 2 == 1)
                chk($sformatf("rr c%0d sd_address", c), 32'(sd_address), 32'h100 + 32'(idx));
            next_cycle();
        end
`endif

        // Tag FIFO full: master 1 stalls after 4 reads, master 2 write still goes.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            m_read  = 4'b0010;
            m_write = (c >= 10) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (c == 1 || c == 3 || c == 5 || c == 7) exp_mwr = 4'b1101;
            else if (c == 11 || c == 13) exp_mwr = 4'b1011;
            else exp_mwr = 4'hF;
            chk($sformatf("full c%0d m_waitrequest", c), 32'(m_waitrequest), 32'(exp_mwr));
            chk($sformatf("full c%0d sd_read", c), 32'(sd_read),
                32'(c == 1 || c == 3 || c == 5 || c == 7));
            chk($sformatf("full c%0d sd_write", c), 32'(sd_write), 32'(c == 11 || c == 13));
            next_cycle();
        end
        idle_inputs();
        for (int r = 0; r < 4; r++) begin
            sd_readdatavalid = 1'b1;
            @(negedge clk);
            chk($sformatf("full ret%0d m_readdatavalid", r), 32'(m_readdatavalid), 32'h2);
            next_cycle();
        end
        sd_readdatavalid = 1'b0;

        // Tag routing: reads from 3,0,2,0 returned in order.
        do_reset();
        do_read(3);
        do_read(0);
        do_read(2);
        do_read(0);
        exp_rdv[0] = 4'b1000;
        exp_rdv[1] = 4'b0001;
        exp_rdv[2] = 4'b0100;
        exp_rdv[3] = 4'b0001;
        for (int r = 0; r < 4; r++) begin
            sd_readdatavalid = 1'b1;
            sd_readdata      = 16'hC000 + 16'(r);
            @(negedge clk);
            chk($sformatf("tag ret%0d m_readdatavalid", r), 32'(m_readdatavalid), 32'(exp_rdv[r]));
            chk($sformatf("tag ret%0d m_readdata", r), 32'(m_readdata), 32'hC000 + 32'(r));
            next_cycle();
        end
        sd_readdatavalid = 1'b0;

        // Reset in the middle of a read; the stale return becomes an orphan.
        do_read(1);
        m_read         = 4'b0010;
        sd_waitrequest = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("midrst pre sd_read", 32'(sd_read), 32'd1);
        reset_reset_n = 1'b0;
        #1;
        chk("midrst sd_read", 32'(sd_read), 32'd0);
        chk("midrst m_waitrequest", 32'(m_waitrequest), 32'hF);
        idle_inputs();
        next_cycle();
        reset_reset_n    = 1'b1;
        sd_readdatavalid = 1'b1;
        @(negedge clk);
        chk("midrst stale m_readdatavalid", 32'(m_readdatavalid), 32'd0);
        next_cycle();
        sd_readdatavalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("orphan sticky c%0d", c), 32'(err_orphan), 32'd1);
            next_cycle();
        end
        reset_reset_n = 1'b0;
        #1;
        chk("orphan cleared by reset", 32'(err_orphan), 32'd0);
        next_cycle();
        reset_reset_n = 1'b1;

        // sd_waitrequest held high for 10 REQ cycles.
        for (int c = 0; c < 13; c++) begin
            m_write        = (c <= 11) ? 4'b0001 : 4'b0000;
            sd_waitrequest = (c <= 10);
            @(negedge clk);
            if (c >= 1 && c <= 11) begin
                chk($sformatf("wait c%0d sd_write", c), 32'(sd_write), 32'd1);
                chk($sformatf("wait c%0d sd_address", c), 32'(sd_address), 32'h100);
                chk($sformatf("wait c%0d sd_writedata", c), 32'(sd_writedata), 32'hA000);
                chk($sformatf("wait c%0d sd_byteenable", c), 32'(sd_byteenable), 32'h1);
            end else begin
                chk($sformatf("wait c%0d sd_write", c), 32'(sd_write), 32'd0);
            end
            chk($sformatf("wait c%0d m_waitrequest", c), 32'(m_waitrequest),
                (c == 11) ? 32'hE : 32'hF);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
